// File: rtl/ir_tx_scheduler_pkg.sv
// Shared types and default sizing for the IR transmit letter scheduler.
package ir_sched_pkg;

  localparam int DEPTH_DEF        = 1000;
  localparam int WIDTH_DEF        = 5;
  localparam int READ_LATENCY_DEF = 2;
  localparam int GAP_CYCLES_DEF   = 100000;
  localparam int BUSY_TIMEOUT_DEF = 1000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } sched_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ir_tx_scheduler_ram.sv
// Letter ring storage: simple dual-port, single-clock RAM with a registered read pipeline.
module letter_ring_ram #(
  parameter int DEPTH        = 1000,
  parameter int WIDTH        = 5,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = 10
) (
  input  logic              clk_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_p [READ_LATENCY];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_p[0] <= mem[rd_addr];
    for (int i = 1; i < READ_LATENCY; i++) rd_data_p[i] <= rd_data_p[i-1];
  end

  assign rd_data = rd_data_p[READ_LATENCY-1];

endmodule

// File: rtl/ir_tx_scheduler.sv
// Buffers letters from the enigma and launches them one at a time into the IR transmitter,
// enforcing a busy handshake and an inter-letter gap.
module ir_tx_scheduler
  import ir_sched_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int WIDTH        = WIDTH_DEF,
  parameter int READ_LATENCY = READ_LATENCY_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       wr_valid_in,
  input  logic [WIDTH-1:0]           wr_data_in,
  input  logic                       tx_enable_in,
  input  logic                       flush_in,
  input  logic                       busy_in,
  output logic                       tx_valid_out,
  output logic [WIDTH-1:0]           tx_data_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic [15:0]                sent_count_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       overflow_out,
  output logic                       timeout_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMR_W = $clog2(max2(max2(GAP_CYCLES, BUSY_TIMEOUT), READ_LATENCY) + 1);

  sched_state_e     state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] tx_data_q;
  logic             launch;
  logic             wr_accept;
  logic             tmo_set;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  letter_ring_ram #(
    .DEPTH        (DEPTH),
    .WIDTH        (WIDTH),
    .READ_LATENCY (READ_LATENCY),
    .ADDR_W       (PTR_W)
  ) u_ram (
    .clk_in  (clk_in),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (wr_data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign launch       = (state == LAUNCH);
  assign full_out     = (count_out == ($clog2(DEPTH+1))'(DEPTH));
  assign empty_out    = (count_out == '0);
  assign wr_accept    = wr_valid_in && !full_out && !flush_in;
  assign tx_valid_out = launch;
  // The RAM word is already settled in the launch cycle; afterwards the captured copy is held.
  assign tx_data_out  = launch ? rd_data : tx_data_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    tmo_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_out && tx_enable_in && !busy_in && !flush_in) begin
          state_nxt = FETCH;
          tmr_nxt   = '0;
        end
      end
      FETCH: begin
        if (flush_in) state_nxt = IDLE;
        else if (tmr == TMR_W'(READ_LATENCY-1)) state_nxt = LAUNCH;
        else tmr_nxt = tmr + 1'b1;
      end
      LAUNCH: begin
        state_nxt = WAIT_BUSY;
        tmr_nxt   = '0;
      end
      WAIT_BUSY: begin
        if (busy_in) begin
          state_nxt = WAIT_DONE;
        end else if (tmr == TMR_W'(BUSY_TIMEOUT-1)) begin
          // Transmitter never answered: the letter is dropped, not retried.
          tmo_set   = 1'b1;
          state_nxt = GAP;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!busy_in) begin
          state_nxt = GAP;
          tmr_nxt   = '0;
        end
      end
      GAP: begin
        if (tmr == TMR_W'(GAP_CYCLES-1)) state_nxt = IDLE;
        else tmr_nxt = tmr + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_out      <= '0;
      sent_count_out <= '0;
      overflow_out   <= 1'b0;
      timeout_out    <= 1'b0;
      tx_data_q      <= '0;
    end else begin
      if (launch) tx_data_q <= rd_data;
      if (flush_in) begin
        wr_ptr         <= '0;
        rd_ptr         <= '0;
        count_out      <= '0;
        sent_count_out <= '0;
        overflow_out   <= 1'b0;
        timeout_out    <= 1'b0;
      end else begin
        if (wr_accept) wr_ptr <= ptr_inc(wr_ptr);
        if (launch) rd_ptr <= ptr_inc(rd_ptr);
        if (wr_accept && !launch) count_out <= count_out + 1'b1;
        else if (!wr_accept && launch) count_out <= count_out - 1'b1;
        if (launch) sent_count_out <= sent_count_out + 16'd1;
        if (wr_valid_in && full_out) overflow_out <= 1'b1;
        if (tmo_set) timeout_out <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ir_tx_scheduler.md
Name: ir_tx_scheduler

Overview:
Sequences coded letters from the enigma into the IR transmitter. It owns a circular letter buffer with 5-bit entries and accepts one letter per write pulse from the enigma. It launches exactly one letter per transmitter transaction using a valid/busy handshake, then waits an inter-letter gap before launching the next. The block sits between enigma (data_valid_out/data_out) and ir_transmitter (data_valid_in/data_in/busy_out), in the 100 MHz domain.

Parameters:
DEPTH, 1000, buffer entries
WIDTH, 5, letter width in bits
READ_LATENCY, 2, buffer read latency in cycles (high-performance RAM)
GAP_CYCLES, 100000, idle cycles enforced after busy_in falls before the next launch (1 ms at 100 MHz)
BUSY_TIMEOUT, 1000, cycles allowed for busy_in to rise after a launch

Ports:
clk_in  input  1  system clock (clk_100_passthrough)
rst_in  input  1  synchronous, active-low reset
wr_valid_in  input  1  single-cycle letter-available strobe from enigma
wr_data_in  input  WIDTH  letter from enigma
tx_enable_in  input  1  when low, no new launch starts; an in-flight transaction completes
flush_in  input  1  synchronous clear of buffer contents and sticky flags; active high
busy_in  input  1  ir_transmitter busy_out
tx_valid_out  output  1  single-cycle launch strobe to ir_transmitter
tx_data_out  output  WIDTH  letter presented with tx_valid_out
count_out  output  $clog2(DEPTH+1)  letters currently buffered
sent_count_out  output  16  letters launched since reset/flush; wraps at 65535
full_out  output  1  count_out == DEPTH
empty_out  output  1  count_out == 0
overflow_out  output  1  sticky; a write arrived while full
timeout_out  output  1  sticky; busy_in never rose within BUSY_TIMEOUT

Behaviour:
- Reset (rst_in low at posedge): all pointers, counters, sticky flags, tx_valid_out and tx_data_out go to 0; empty_out=1; FSM enters IDLE. Reset mid-transaction abandons the transaction and issues no further strobe.
- Write: on wr_valid_in with !full, the block stores the letter at wr_ptr. wr_ptr wraps from DEPTH-1 to 0. A write while full is dropped, sets overflow_out and leaves count unchanged.
- Pointers and count: rd_ptr advances in LAUNCH and wraps from DEPTH-1 to 0. When a write and a LAUNCH happen in the same cycle, count is unchanged.
- FSM:
  - IDLE: go to FETCH when count>0, tx_enable_in=1 and busy_in=0.
  - FETCH: present rd_ptr to RAM and hold for READ_LATENCY cycles, then go to LAUNCH.
  - LAUNCH: one cycle. tx_valid_out=1, tx_data_out=RAM output. rd_ptr++, count--, sent_count++. Go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when busy_in=1. If busy_in stays low for BUSY_TIMEOUT cycles, set timeout_out and go to GAP; the letter is considered consumed and is not retried.
  - WAIT_DONE: go to GAP when busy_in=0.
  - GAP: count GAP_CYCLES, then go to IDLE.
- Launch latency: from the IDLE condition becoming true to tx_valid_out is READ_LATENCY+1 cycles (3 at default). Minimum spacing between strobes is transmit time + GAP_CYCLES + READ_LATENCY + 2.
- tx_data_out holds its value after LAUNCH until the next LAUNCH.
- Write during FETCH: fully supported. A write to the slot being read cannot occur, because that slot is occupied.
- flush_in: same effect as reset on buffer, counts and flags. If asserted during WAIT_BUSY or WAIT_DONE, the FSM still tracks busy_in to completion, then enters GAP. If asserted in FETCH, the FSM returns to IDLE without launching. flush_in wins over a simultaneous write.
- tx_enable_in low: freezes only the IDLE→FETCH transition.

Decomposition:
- Package ir_sched_pkg holds the FSM state enum (IDLE, FETCH, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP) and default constants (DEPTH, GAP_CYCLES, BUSY_TIMEOUT).
- Sub-module letter_ring_ram: a simple dual-port, one-clock RAM wrapper with READ_LATENCY output registers. The scheduler keeps pointers and count itself.

Test Plan:
- Single letter: write 5'd7 with a bus-functional transmitter (busy rises 2 cycles after the strobe, lasts 500 cycles) -> tx_valid_out pulses once after 3 cycles with data 7; count 1→0; sent_count=1; next launch no sooner than GAP_CYCLES after busy falls (test GAP_CYCLES=50).
- Burst: write letters 0..9 back-to-back -> 10 launches in order 0..9; each strobe is separated by ≥ transmit time + gap; empty_out=1 at the end.
- Wrap and full, DEPTH=8: write 8 letters -> full_out=1; 9th write dropped and overflow_out=1; drain all, then write 3 more -> they are read from slots 0..2 after wrap, order preserved.
- Simultaneous write and launch at count=2 -> count stays 2 that cycle; no data loss.
- Timeout: busy_in tied low with BUSY_TIMEOUT=20 -> timeout_out=1 after 20 cycles; the next letter still launches after the gap.
- Reset/flush mid-WAIT_DONE: drive rst_in low -> all outputs return to reset values and no stray tx_valid_out. Repeat with flush_in -> count=0, and the FSM waits for busy low before GAP.
